// File: rtl/reg_file_pkg.sv
// Shared constants and types for the general-purpose register file,
// reused by the decode and write-back stages.
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational NUM_REGS:1 read mux of the register file.
// Optional macro ZERO_REG_EN forces reads of register 0 to return zero.
module reg_file_read_port
    import reg_file_pkg::*;
(
    input  reg_array_t regs,
    input  reg_addr_t  addr,
    output reg_data_t  data
);

    always_comb begin
`ifdef ZERO_REG_EN
        if (addr == '0) begin
            data = '0;
        end else begin
            data = regs[addr];
        end
`else
        data = regs[addr];
`endif
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// Optional macro ZERO_REG_EN hardwires register 0 to zero.
module reg_file_2r1w
    import reg_file_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg_num1,
    input  logic [ADDR_W-1:0] read_reg_num2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              regwrite
);

    if (NUM_REGS != 2**ADDR_W) begin : g_size_check
        $error("reg_file_2r1w: NUM_REGS must equal 2**ADDR_W");
    end

    reg_array_t          regs;
    logic [NUM_REGS-1:0] write_sel;

    always_comb begin
        write_sel = '0;
        if (regwrite) begin
            write_sel[write_reg] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
`ifdef ZERO_REG_EN
        if (i == 0) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_flop
`else
        begin : g_flop
`endif
            // Async clear dominates any write, including one coincident with an edge.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    regs[i] <= '0;
                end else if (write_sel[i]) begin
                    regs[i] <= write_data;
                end
            end
        end
    end

    reg_file_read_port u_read_port1 (
        .regs (regs),
        .addr (read_reg_num1),
        .data (read_data1)
    );

    reg_file_read_port u_read_port2 (
        .regs (regs),
        .addr (read_reg_num2),
        .data (read_data2)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed vector table, corner
// sequences and randomized traffic against an array reference model.
module tb_reg_file_2r1w;
    import reg_file_pkg::*;

    logic      clock;
    logic      reset;
    reg_addr_t read_reg_num1;
    reg_addr_t read_reg_num2;
    reg_addr_t write_reg;
    reg_data_t write_data;
    reg_data_t read_data1;
    reg_data_t read_data2;
    logic      regwrite;

    int tests;
    int fails;

    reg_data_t model [NUM_REGS];

`ifdef ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    reg_file_2r1w dut (
        .clock         (clock),
        .reset         (reset),
        .read_reg_num1 (read_reg_num1),
        .read_reg_num2 (read_reg_num2),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .regwrite      (regwrite)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic      we;
        reg_addr_t wa;
        reg_data_t wd;
        reg_addr_t ra1;
        reg_addr_t ra2;
        reg_data_t exp1;
        reg_data_t exp2;
    } vec_t;

    vec_t vecs [6];

    function automatic reg_data_t expect_rd(input reg_addr_t a);
        if (ZERO_EN && a == 0) return '0;
        return model[a];
    endfunction

    task automatic check(input string name, input reg_data_t act, input reg_data_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    endtask

    // Drive on the falling edge, optionally check old values before the rising
    // edge, then update the model and check the post-edge values.
    task automatic cycle(input logic we, input reg_addr_t wa, input reg_data_t wd,
                         input reg_addr_t ra1, input reg_addr_t ra2, input bit pre_check);
        @(negedge clock);
        regwrite = we; write_reg = wa; write_data = wd;
        read_reg_num1 = ra1; read_reg_num2 = ra2;
        if (pre_check) begin
            #1;
            check("pre_edge_rd1", read_data1, expect_rd(ra1));
            check("pre_edge_rd2", read_data2, expect_rd(ra2));
        end
        @(posedge clock);
        if (we && reset) model[wa] = wd;
        #1;
    endtask

    reg_data_t r0_exp;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        regwrite = 1'b0; write_reg = '0; write_data = '0;
        read_reg_num1 = '0; read_reg_num2 = 5'd31;
        clear_model();
        r0_exp = ZERO_EN ? 32'd0 : 32'd20;

        // Reset state
        #12;
        check("reset_rd1_r0", read_data1, 32'd0);
        check("reset_rd2_r31", read_data2, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        vecs[0] = '{1'b1, 5'd1,  32'd30,        5'd0,  5'd1,  32'd0,        32'd30};
        vecs[1] = '{1'b0, 5'd1,  32'hDEADBEEF,  5'd1,  5'd2,  32'd30,       32'd0};
        vecs[2] = '{1'b0, 5'd1,  32'hDEADBEEF,  5'd1,  5'd2,  32'd30,       32'd0};
        vecs[3] = '{1'b1, 5'd0,  32'd20,        5'd0,  5'd1,  r0_exp,       32'd30};
        vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF,  5'd31, 5'd30, 32'hFFFFFFFF, 32'd0};
        vecs[5] = '{1'b1, 5'd2,  32'hA5A5A5A5,  5'd2,  5'd2,  32'hA5A5A5A5, 32'hA5A5A5A5};

        for (int v = 0; v < 6; v++) begin
            cycle(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2, 1'b0);
            check($sformatf("vec%0d_rd1", v), read_data1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), read_data2, vecs[v].exp2);
        end
        // Table writes are mirrored into the model; r0 rule applied here.
        if (ZERO_EN) model[0] = '0;

        // Read-during-write: old value before the edge, new value after it
        @(negedge clock);
        regwrite = 1'b1; write_reg = 5'd5; write_data = 32'h1234;
        read_reg_num1 = 5'd5; read_reg_num2 = 5'd5;
        #1;
        check("rdw_before_rd1", read_data1, 32'd0);
        check("rdw_before_rd2", read_data2, 32'd0);
        @(posedge clock);
        #1;
        check("rdw_after_rd1", read_data1, 32'h1234);
        check("rdw_after_rd2", read_data2, 32'h1234);
        model[5] = 32'h1234;

        // Full sweep
        for (int i = 0; i < NUM_REGS; i++) begin
            cycle(1'b1, reg_addr_t'(i), reg_data_t'(i) * 32'h01010101, '0, '0, 1'b0);
        end
        if (ZERO_EN) model[0] = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_data_t e1, e2;
            e1 = (ZERO_EN && i == 0) ? 32'd0 : reg_data_t'(i) * 32'h01010101;
            e2 = (ZERO_EN && i == 31) ? 32'd0 : reg_data_t'(31 - i) * 32'h01010101;
            read_reg_num1 = reg_addr_t'(i);
            read_reg_num2 = reg_addr_t'(31 - i);
            #1;
            check($sformatf("sweep_rd1_r%0d", i), read_data1, e1);
            check($sformatf("sweep_rd2_r%0d", 31 - i), read_data2, e2);
        end

        // Reset asserted between edges clears immediately; writes ignored while held
        @(negedge clock);
        regwrite = 1'b1; write_reg = 5'd1; write_data = 32'h5555AAAA;
        read_reg_num1 = 5'd1; read_reg_num2 = 5'd31;
        #2;
        reset = 1'b0;
        #1;
        check("midreset_rd1_r1", read_data1, 32'd0);
        check("midreset_rd2_r31", read_data2, 32'd0);
        clear_model();
        #10;
        check("held_reset_rd1_r1", read_data1, 32'd0);
        read_reg_num1 = 5'd0;
        #1;
        check("held_reset_rd1_r0", read_data1, 32'd0);

        // Release: the write presented at the first rising edge is performed
        @(negedge clock);
        reset = 1'b1;
        regwrite = 1'b1; write_reg = 5'd3; write_data = 32'h33;
        read_reg_num1 = 5'd3;
        @(posedge clock);
        #1;
        check("release_write_r3", read_data1, 32'h33);
        model[3] = 32'h33;

        // Reset coincident with a write edge wins
        @(negedge clock);
        regwrite = 1'b1; write_reg = 5'd7; write_data = 32'h77;
        read_reg_num1 = 5'd7; read_reg_num2 = 5'd3;
        @(posedge clock);
        reset = 1'b0;
        #1;
        check("coincident_reset_r7", read_data1, 32'd0);
        check("coincident_reset_r3", read_data2, 32'd0);
        clear_model();
        @(negedge clock);
        reset = 1'b1;
        regwrite = 1'b0;

        // Randomized traffic against the array model
        for (int n = 0; n < 400; n++) begin
            logic      we;
            reg_addr_t wa, ra1, ra2;
            reg_data_t wd;
            we  = 1'($urandom_range(0, 3) != 0);
            wa  = reg_addr_t'($urandom);
            wd  = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa : reg_addr_t'($urandom);
            ra2 = ($urandom_range(0, 3) == 0) ? ra1 : reg_addr_t'($urandom);
            cycle(we, wa, wd, ra1, ra2, (n % 4) == 0);
            if (ZERO_EN) model[0] = '0;
            check("rand_rd1", read_data1, expect_rd(ra1));
            check("rand_rd2", read_data2, expect_rd(ra2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
